// File: rtl/wb_ram_slave_if.sv
// Wishbone bus bundle for the 8-bit CPU bus: address, tag, data, and handshake.
// The master modport belongs to the CPU side; the slave modport belongs to a responder.
interface wb_ram_slave_if;
  logic [15:0] wbs_adr_i;
  logic [1:0]  wbs_tga_i;
  logic [7:0]  wbs_dat_i;
  logic [7:0]  wbs_dat_o;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic        wbs_ack_o;

  modport master (
    output wbs_adr_i, wbs_tga_i, wbs_dat_i, wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_adr_i, wbs_tga_i, wbs_dat_i, wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone RAM responder: decodes a memory-tagged window and serves byte reads/writes
// from block RAM. It performs exactly one access per strobe after WAIT_STATES extra clocks.
module wb_ram_slave #(
  parameter int          ADDR_WIDTH  = 14,
  parameter logic [15:0] BASE_ADDR   = 16'h4000,
  parameter int          WAIT_STATES = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_ram_slave_if.slave   wb,
  input  logic            wp_i,
  output logic            hit_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] WCNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                  state;
  logic [3:0]              wcnt;
  logic                    ack_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic                    we_q;
  logic                    bus_active;
  logic                    req;
  logic                    do_access;
  logic [ADDR_WIDTH-1:0]   access_adr;
  logic                    access_we;

  // NOTE: RAM has no reset; a reset loop over every word would stop it mapping to block RAM.
  logic [7:0] mem [2**ADDR_WIDTH];

  assign hit_o      = (wb.wbs_tga_i == 2'b00) &&
                      (wb.wbs_adr_i[15:ADDR_WIDTH] == BASE_ADDR[15:ADDR_WIDTH]);
  assign bus_active = wb.wbs_cyc_i & wb.wbs_stb_i;
  assign req        = bus_active & hit_o;
  assign wb.wbs_ack_o = ack_q & bus_active;

  // With zero wait states the access happens on the accepting edge, before adr_q/we_q exist.
  assign access_adr = (state == S_IDLE) ? wb.wbs_adr_i[ADDR_WIDTH-1:0] : adr_q;
  assign access_we  = (state == S_IDLE) ? wb.wbs_we_i : we_q;
  assign do_access  = !rst_i &&
                      (((state == S_IDLE) && req && (WAIT_STATES == 0)) ||
                       ((state == S_WAIT) && bus_active && (wcnt == 4'd0)));

  always_ff @(posedge clk_i) begin
    if (do_access && access_we && !wp_i) begin
      mem[access_adr] <= wb.wbs_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      wcnt         <= 4'd0;
      ack_q        <= 1'b0;
      adr_q        <= '0;
      we_q         <= 1'b0;
      wb.wbs_dat_o <= 8'h00;
    end else begin
      if (do_access && !access_we) begin
        wb.wbs_dat_o <= mem[access_adr];
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            adr_q <= wb.wbs_adr_i[ADDR_WIDTH-1:0];
            we_q  <= wb.wbs_we_i;
            if (WAIT_STATES == 0) begin
              state <= S_ACK;
              ack_q <= 1'b1;
            end else begin
              wcnt  <= WCNT_INIT;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus_active) begin
            state <= S_IDLE;
          end else if (wcnt == 4'd0) begin
            state <= S_ACK;
            ack_q <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        S_ACK: begin
          if (!bus_active) begin
            state <= S_IDLE;
            ack_q <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: three instances (1, 3 and 0 wait states) share one
// stimulus bus; sel gates cyc/stb to the addressed instance and muxes its responses back.
module tb_wb_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        wp;
  logic [1:0]  sel;
  logic [15:0] adr;
  logic [1:0]  tga;
  logic [7:0]  dout;
  logic        cyc, stb, we;
  logic        hit1, hit3, hit0;
  logic        ack_m, hit_m;
  logic [7:0]  rdat_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_ram_slave_if bus1 ();
  wb_ram_slave_if bus3 ();
  wb_ram_slave_if bus0 ();

  assign bus1.wbs_adr_i = adr;  assign bus3.wbs_adr_i = adr;  assign bus0.wbs_adr_i = adr;
  assign bus1.wbs_tga_i = tga;  assign bus3.wbs_tga_i = tga;  assign bus0.wbs_tga_i = tga;
  assign bus1.wbs_dat_i = dout; assign bus3.wbs_dat_i = dout; assign bus0.wbs_dat_i = dout;
  assign bus1.wbs_we_i  = we;   assign bus3.wbs_we_i  = we;   assign bus0.wbs_we_i  = we;
  assign bus1.wbs_cyc_i = cyc & (sel == 2'd1);
  assign bus3.wbs_cyc_i = cyc & (sel == 2'd3);
  assign bus0.wbs_cyc_i = cyc & (sel == 2'd0);
  assign bus1.wbs_stb_i = stb & (sel == 2'd1);
  assign bus3.wbs_stb_i = stb & (sel == 2'd3);
  assign bus0.wbs_stb_i = stb & (sel == 2'd0);

  wb_ram_slave #(.ADDR_WIDTH(14), .BASE_ADDR(16'h4000), .WAIT_STATES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .wb(bus1), .wp_i(wp), .hit_o(hit1));
  wb_ram_slave #(.ADDR_WIDTH(14), .BASE_ADDR(16'h4000), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .wb(bus3), .wp_i(wp), .hit_o(hit3));
  wb_ram_slave #(.ADDR_WIDTH(14), .BASE_ADDR(16'h4000), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .wb(bus0), .wp_i(wp), .hit_o(hit0));

  always_comb begin
    ack_m  = bus0.wbs_ack_o;
    rdat_m = bus0.wbs_dat_o;
    hit_m  = hit0;
    case (sel)
      2'd1: begin ack_m = bus1.wbs_ack_o; rdat_m = bus1.wbs_dat_o; hit_m = hit1; end
      2'd3: begin ack_m = bus3.wbs_ack_o; rdat_m = bus3.wbs_dat_o; hit_m = hit3; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge. Holds strobe for `hold` clocks after the
  // first acknowledge, switching write data to d2 meanwhile, then drops strobe.
  task automatic xfer(input string tag, input logic w, input logic [15:0] a,
                      input logic [7:0] d, input logic [7:0] d2, input int hold,
                      input int exp_lat, output logic [7:0] rd);
    int lat;
    adr = a; we = w; dout = d; tga = 2'b00; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!ack_m && lat < 20);
    check({tag, "_latency"}, 16'(lat), 16'(exp_lat));
    rd = rdat_m;
    dout = d2;
    repeat (hold) begin
      @(negedge clk);
      if (!w) check({tag, "_data_stable"}, {8'h00, rdat_m}, {8'h00, rd});
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    #1;
    check({tag, "_ack_drop"}, {15'd0, ack_m}, 16'd0);
    @(posedge clk); #1;
  endtask

  logic [7:0] rd;
  bit seen_ack;

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wp = 1'b0; sel = 2'd1; adr = 16'h0000; tga = 2'b00; dout = 8'h00;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ack", {15'd0, ack_m}, 16'd0);
    check("reset_dat", {8'h00, rdat_m}, 16'h0000);
    check("reset_hit_outside", {15'd0, hit_m}, 16'd0);
    @(posedge clk); #1;

    // Write then read, one wait state.
    xfer("w_a5", 1'b1, 16'h4123, 8'hA5, 8'h5A, 3, 2, rd);
    xfer("r_a5", 1'b0, 16'h4123, 8'h00, 8'h00, 1, 2, rd);
    check("r_a5_data", {8'h00, rd}, 16'h00A5);

    // Data change during ACK must not cause a second write.
    xfer("w_11", 1'b1, 16'h4010, 8'h11, 8'h22, 3, 2, rd);
    xfer("r_11", 1'b0, 16'h4010, 8'h00, 8'h00, 0, 2, rd);
    check("r_11_data", {8'h00, rd}, 16'h0011);

    // Decode: outside window, then I/O tag.
    adr = 16'h8000; tga = 2'b00; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    #1 check("miss_adr_hit", {15'd0, hit_m}, 16'd0);
    seen_ack = 1'b0;
    repeat (20) begin @(negedge clk); if (ack_m) seen_ack = 1'b1; end
    check("miss_adr_ack", {15'd0, seen_ack}, 16'd0);
    adr = 16'h4000; tga = 2'b01;
    #1 check("miss_tag_hit", {15'd0, hit_m}, 16'd0);
    seen_ack = 1'b0;
    repeat (20) begin @(negedge clk); if (ack_m) seen_ack = 1'b1; end
    check("miss_tag_ack", {15'd0, seen_ack}, 16'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; tga = 2'b00;
    @(posedge clk); #1;
    adr = 16'h7FFF;
    #1 check("last_byte_hit", {15'd0, hit_m}, 16'd1);
    xfer("w_7fff", 1'b1, 16'h7FFF, 8'hC3, 8'hC3, 0, 2, rd);
    xfer("r_7fff", 1'b0, 16'h7FFF, 8'h00, 8'h00, 0, 2, rd);
    check("r_7fff_data", {8'h00, rd}, 16'h00C3);

    // Write protect.
    xfer("w_3c", 1'b1, 16'h4001, 8'h3C, 8'h3C, 0, 2, rd);
    wp = 1'b1;
    xfer("w_wp", 1'b1, 16'h4001, 8'hFF, 8'hFF, 0, 2, rd);
    wp = 1'b0;
    xfer("r_wp", 1'b0, 16'h4001, 8'h00, 8'h00, 0, 2, rd);
    check("r_wp_data", {8'h00, rd}, 16'h003C);

    // Abort and reset, three wait states.
    sel = 2'd3;
    xfer("w3_5a", 1'b1, 16'h4200, 8'h5A, 8'h5A, 0, 4, rd);
    adr = 16'h4200; we = 1'b1; dout = 8'h77; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    seen_ack = 1'b0;
    repeat (6) begin @(negedge clk); if (ack_m) seen_ack = 1'b1; end
    check("abort_ack", {15'd0, seen_ack}, 16'd0);
    @(posedge clk); #1;
    xfer("r3_abort", 1'b0, 16'h4200, 8'h00, 8'h00, 0, 4, rd);
    check("r3_abort_data", {8'h00, rd}, 16'h005A);
    adr = 16'h4200; we = 1'b1; dout = 8'h77; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wait_ack", {15'd0, ack_m}, 16'd0);
    check("rst_wait_dat", {8'h00, rdat_m}, 16'h0000);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    xfer("r3_rst", 1'b0, 16'h4200, 8'h00, 8'h00, 0, 4, rd);
    check("r3_rst_data", {8'h00, rd}, 16'h005A);

    // Zero wait states.
    sel = 2'd0;
    xfer("w0_0", 1'b1, 16'h4000, 8'h10, 8'h10, 0, 1, rd);
    xfer("w0_1", 1'b1, 16'h4001, 8'h21, 8'h21, 0, 1, rd);
    xfer("w0_2", 1'b1, 16'h4002, 8'h32, 8'h32, 0, 1, rd);
    xfer("w0_3", 1'b1, 16'h4003, 8'h43, 8'h43, 0, 1, rd);
    xfer("r0_0", 1'b0, 16'h4000, 8'h00, 8'h00, 1, 1, rd);
    check("r0_0_data", {8'h00, rd}, 16'h0010);
    xfer("r0_1", 1'b0, 16'h4001, 8'h00, 8'h00, 1, 1, rd);
    check("r0_1_data", {8'h00, rd}, 16'h0021);
    xfer("r0_2", 1'b0, 16'h4002, 8'h00, 8'h00, 1, 1, rd);
    check("r0_2_data", {8'h00, rd}, 16'h0032);
    xfer("r0_3", 1'b0, 16'h4003, 8'h00, 8'h00, 1, 1, rd);
    check("r0_3_data", {8'h00, rd}, 16'h0043);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
